mem_port_arbiter4: RTL and testbench
====================================

# mem_port_arbiter4

Round-robin arbiter sharing the core's single memory port between up to four requesters: instruction fetch, load/store unit, debug module and a spare slot. It produces a one-hot grant and a 2-bit select that drives the `s` input of the existing 4-way datapath multiplexer, which steers address, write-data and control onto the port. A grant is held from acceptance until the memory signals completion. Sits between the pipeline front-ends and the memory interface.

## Interface
- `TIMEOUT_CYCLES`, 256: maximum busy cycles before forced release; only used with the watchdog compiled in; must be ≥ 2.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `req` in 4: request per requester; bit i belongs to requester i. Must stay high until that requester's transaction completes.
- `bus_ready` in 1: memory completion strobe; sampled only in BUSY.
- `grant` out 4: one-hot grant, or all zero; registered.
- `sel` out 2: binary index of the current or last winner; drives the mux select; registered.
- `bus_valid` out 1: high while a granted transaction is outstanding; registered.
- `timeout_err` out 1: one-cycle pulse on forced release; present only with the watchdog compiled in.

## Operation
- States: IDLE and BUSY. Internal state: `ptr[1:0]` (highest-priority index) and `win[1:0]`.
- Arbitration: the first set `req` bit scanning `ptr`, `ptr+1`, `ptr+2`, `ptr+3`. Indices wrap modulo 4 (3+1 → 0).
- IDLE with any `req` set:
  - Go to BUSY.
  - `win` = winner; `grant` = one-hot(winner); `sel` = winner; `bus_valid` = 1.
- IDLE with no `req` set: stay in IDLE; `grant` = 0; `bus_valid` = 0; `sel` holds its last value.
- BUSY without `bus_ready`: hold every output. This applies even if `req[win]` drops; a dropped request is a requester protocol violation and the arbiter ignores it.
- BUSY with `bus_ready`:
  - Set `ptr` = `win`+1.
  - Arbitrate in the same cycle using the new `ptr` and the current `req`. If a winner exists, stay in BUSY with a back-to-back grant to it; otherwise go to IDLE with `grant` = 0 and `bus_valid` = 0.
  - A sole requester that just completed therefore wins again.
- `bus_ready` is ignored in IDLE.
- Invariants: `grant` is never multi-hot. `bus_valid` equals the OR of `grant`. When `bus_valid` = 1, `sel` equals the index of `grant`.

## Timing
- Reset (`rst_n` = 0 at an edge): state IDLE, `grant` = 4'b0000, `sel` = 2'b00, `bus_valid` = 0, `ptr` = 0, `win` = 0, `timeout_err` = 0, watchdog counter = 0.
- Reset mid-transaction aborts it immediately. No completion is owed.
- Grant latency: `req` high at edge N in IDLE gives `grant` and `bus_valid` visible after edge N.
- Completion: `bus_ready` sampled high at edge M. The new grant, or the release, is visible after edge M. There is no bubble between back-to-back grants.
- Minimum transaction length: 1 cycle (`bus_ready` high on the first BUSY cycle).
- All outputs come from registers. There is no combinational path from `req` or `bus_ready` to any output.

## Configuration
- Macro: `MEM_ARB_WATCHDOG_EN`.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYCLES)+1 clears on every new grant and increments each BUSY cycle without `bus_ready`.
  - When it reaches `TIMEOUT_CYCLES`, that edge behaves as a `bus_ready` completion: `ptr` advances and the next requester is arbitrated. `timeout_err` pulses high for exactly one cycle.
  - `bus_ready` arriving on the same edge as the timeout counts as a normal completion: no `timeout_err`.
- Undefined: no counter and no `timeout_err` port; BUSY waits indefinitely for `bus_ready`.

## Test plan
- Reset/idle: hold `rst_n` = 0 for 2 cycles with `req` = 4'b1111, then release with `req` = 0 → `grant` = 0, `sel` = 0, `bus_valid` = 0 for all cycles.
- Single request: `req` = 4'b0100 and `bus_ready` pulses on the 3rd BUSY cycle:
  - `grant` = 4'b0100 and `sel` = 2 one cycle after `req`, held 3 cycles.
  - Then `grant` = 0 with `req` dropped.
- Round-robin fairness: `req` = 4'b1111 held, `bus_ready` = 1 constantly → `sel` sequence 0,1,2,3,0,1 with no idle cycles between grants.
- Wrap and skip: after a completion by requester 3, `req` = 4'b0101 → requester 0 wins next, then requester 2.
- Reset mid-transaction: `rst_n` = 0 while BUSY with `grant` = 4'b0010 → after the edge, `grant` = 0 and `bus_valid` = 0; the next request from 4'b1010 grants requester 1 (`ptr` = 0).
- Watchdog (macro defined, `TIMEOUT_CYCLES` = 4): `req` = 4'b0011, no `bus_ready` → requester 0 is released after 4 BUSY cycles, `timeout_err` is high one cycle, and requester 1 is granted on the same edge.

Source files
------------

// File: rtl/mem_port_arbiter4_if.sv
// Memory-port arbitration bundle: requests and completion in, grant/select out.
// timeout_err exists only when MEM_ARB_WATCHDOG_EN is defined.
interface mem_port_arbiter4_if;
  logic [3:0] req;
  logic       bus_ready;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       bus_valid;
`ifdef MEM_ARB_WATCHDOG_EN
  logic       timeout_err;
`endif

  // Requester/memory side
  modport master (
    output req,
    output bus_ready,
    input  grant,
    input  sel,
`ifdef MEM_ARB_WATCHDOG_EN
    input  timeout_err,
`endif
    input  bus_valid
  );

  // Arbiter side
  modport slave (
    input  req,
    input  bus_ready,
    output grant,
    output sel,
`ifdef MEM_ARB_WATCHDOG_EN
    output timeout_err,
`endif
    output bus_valid
  );
endinterface

// File: rtl/mem_port_arbiter4.sv
// Four-way round-robin arbiter for the shared memory port; grant held until bus_ready.
// Optional busy watchdog with forced release: define MEM_ARB_WATCHDOG_EN.
module mem_port_arbiter4 #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_port_arbiter4_if.slave bif
);

  localparam int unsigned NREQ = 4;
  localparam int unsigned IDXW = 2;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  if (TIMEOUT_CYCLES < 2) begin : g_timeout_check
    $error("mem_port_arbiter4: TIMEOUT_CYCLES must be at least 2");
  end

  state_t            state, state_d;
  logic [IDXW-1:0]   ptr, ptr_d;
  logic [IDXW-1:0]   win, win_d;
  logic [IDXW-1:0]   sel_q, sel_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic              valid_q, valid_d;
  logic [IDXW-1:0]   arb_ptr;
  logic [IDXW-1:0]   scan_idx;
  logic [IDXW-1:0]   winner;
  logic              found;
  logic              done;

`ifdef MEM_ARB_WATCHDOG_EN
  localparam int unsigned CNTW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CNTW-1:0]   cnt, cnt_d;
  logic              timeout_c;
  logic              terr_q;

  // Last stalled cycle: the counter would reach the limit on this edge
  assign timeout_c = (state == BUSY) && !bif.bus_ready &&
                     (cnt == CNTW'(TIMEOUT_CYCLES - 1));
  assign done      = (state == BUSY) && (bif.bus_ready || timeout_c);
  assign bif.timeout_err = terr_q;
`else
  assign done      = (state == BUSY) && bif.bus_ready;
`endif

  // On completion the search starts just past the finishing requester
  assign arb_ptr = (state == BUSY) ? IDXW'(win + 1'b1) : ptr;

  // First set request scanning arb_ptr, arb_ptr+1, ... modulo 4
  always_comb begin
    found    = 1'b0;
    winner   = arb_ptr;
    scan_idx = arb_ptr;
    for (int unsigned k = 0; k < NREQ; k++) begin
      scan_idx = IDXW'(arb_ptr + IDXW'(k));
      if (!found && bif.req[scan_idx]) begin
        found  = 1'b1;
        winner = scan_idx;
      end
    end
  end

  // State register plus registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= '0;
      win     <= '0;
      sel_q   <= '0;
      grant_q <= '0;
      valid_q <= 1'b0;
`ifdef MEM_ARB_WATCHDOG_EN
      cnt     <= '0;
      terr_q  <= 1'b0;
`endif
    end else begin
      state   <= state_d;
      ptr     <= ptr_d;
      win     <= win_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
`ifdef MEM_ARB_WATCHDOG_EN
      cnt     <= cnt_d;
      terr_q  <= timeout_c;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (found) state_d = BUSY;
      BUSY: if (done && !found) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next register values for pointer, winner and outputs
  always_comb begin
    ptr_d   = ptr;
    win_d   = win;
    sel_d   = sel_q;
    grant_d = grant_q;
    valid_d = valid_q;
    case (state)
      IDLE: begin
        if (found) begin
          win_d   = winner;
          sel_d   = winner;
          grant_d = NREQ'(1) << winner;
          valid_d = 1'b1;
        end else begin
          grant_d = '0;
          valid_d = 1'b0;
        end
      end
      BUSY: begin
        if (done) begin
          ptr_d = arb_ptr;
          if (found) begin
            win_d   = winner;
            sel_d   = winner;
            grant_d = NREQ'(1) << winner;
            valid_d = 1'b1;
          end else begin
            grant_d = '0;
            valid_d = 1'b0;
          end
        end
      end
      default: begin
        grant_d = '0;
        valid_d = 1'b0;
      end
    endcase
`ifdef MEM_ARB_WATCHDOG_EN
    cnt_d = ((state == BUSY) && !done) ? CNTW'(cnt + CNTW'(1)) : '0;
`endif
  end

  assign bif.grant     = grant_q;
  assign bif.sel       = sel_q;
  assign bif.bus_valid = valid_q;

endmodule

// File: tb/tb_mem_port_arbiter4.sv
// Self-checking bench for mem_port_arbiter4: directed scenarios plus randomized
// traffic against a transaction-level round-robin reference model.
module tb_mem_port_arbiter4;

  localparam int unsigned TO = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   fails;

  mem_port_arbiter4_if bif ();

  mem_port_arbiter4 #(.TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bif   (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  bit         m_busy;
  int         m_ptr;
  int         m_win;
  logic [3:0] m_grant;
  logic [1:0] m_sel;
  logic       m_valid;
`ifdef MEM_ARB_WATCHDOG_EN
  int         m_cnt;
  logic       m_terr;
`endif

  function automatic int pick(int p, logic [3:0] r);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  function automatic void model_grant(int w);
    m_busy  = 1'b1;
    m_win   = w;
    m_grant = 4'(1 << w);
    m_sel   = 2'(w);
    m_valid = 1'b1;
`ifdef MEM_ARB_WATCHDOG_EN
    m_cnt   = 0;
`endif
  endfunction

  function automatic void model_release();
    m_busy  = 1'b0;
    m_grant = 4'b0000;
    m_valid = 1'b0;
  endfunction

  function automatic void model_step(logic rn, logic [3:0] r, logic rdy);
    int w;
    bit fin;
    if (!rn) begin
      m_busy = 1'b0; m_ptr = 0; m_win = 0;
      m_grant = 4'b0000; m_sel = 2'b00; m_valid = 1'b0;
`ifdef MEM_ARB_WATCHDOG_EN
      m_cnt = 0; m_terr = 1'b0;
`endif
      return;
    end
`ifdef MEM_ARB_WATCHDOG_EN
    m_terr = 1'b0;
`endif
    if (!m_busy) begin
      w = pick(m_ptr, r);
      if (w >= 0) model_grant(w);
      else model_release();
    end else begin
      fin = rdy;
`ifdef MEM_ARB_WATCHDOG_EN
      if (!rdy) begin
        m_cnt++;
        if (m_cnt == int'(TO)) begin
          fin    = 1'b1;
          m_terr = 1'b1;
        end
      end
`endif
      if (fin) begin
        m_ptr = (m_win + 1) % 4;
        w = pick(m_ptr, r);
        if (w >= 0) model_grant(w);
        else model_release();
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step(rst_n, bif.req, bif.bus_ready);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bif.req = 4'b1111; bif.bus_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin rst_n = 1'b1; bif.req = 4'b0000; end
      tick();
      checks++;
      if (bif.grant !== 4'b0000) begin
        fails++; $display("FAIL reset_grant cyc%0d: got %b want 0000", i, bif.grant);
      end
      checks++;
      if (bif.sel !== 2'b00) begin
        fails++; $display("FAIL reset_sel cyc%0d: got %0d want 0", i, bif.sel);
      end
      checks++;
      if (bif.bus_valid !== 1'b0) begin
        fails++; $display("FAIL reset_valid cyc%0d: got %b want 0", i, bif.bus_valid);
      end
    end
  endtask

  task automatic test_single_request();
    bif.req = 4'b0100; bif.bus_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) bif.bus_ready = 1'b0;
      tick();
      checks++;
      if (bif.grant !== 4'b0100 || bif.sel !== 2'd2 || bif.bus_valid !== 1'b1) begin
        fails++;
        $display("FAIL single_hold cyc%0d: got grant=%b sel=%0d valid=%b want 0100/2/1",
                 i, bif.grant, bif.sel, bif.bus_valid);
      end
    end
    bif.bus_ready = 1'b1; bif.req = 4'b0000;
    tick();
    checks++;
    if (bif.grant !== 4'b0000 || bif.bus_valid !== 1'b0 || bif.sel !== 2'd2) begin
      fails++;
      $display("FAIL single_release: got grant=%b valid=%b sel=%0d want 0000/0/2",
               bif.grant, bif.bus_valid, bif.sel);
    end
    bif.bus_ready = 1'b0;
  endtask

  task automatic test_round_robin();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    bif.req = 4'b1111; bif.bus_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (bif.sel !== 2'(i % 4) || bif.grant !== 4'(1 << (i % 4)) || bif.bus_valid !== 1'b1) begin
        fails++;
        $display("FAIL rr_seq step%0d: got sel=%0d grant=%b valid=%b want sel=%0d",
                 i, bif.sel, bif.grant, bif.bus_valid, i % 4);
      end
    end
    bif.req = 4'b0000;
    tick();
    checks++;
    if (bif.grant !== 4'b0000 || bif.sel !== 2'd1) begin
      fails++; $display("FAIL rr_release: got grant=%b sel=%0d want 0000/1", bif.grant, bif.sel);
    end
    bif.bus_ready = 1'b0;
  endtask

  task automatic test_wrap_skip();
    bif.req = 4'b1000; bif.bus_ready = 1'b0;
    tick();
    checks++;
    if (bif.grant !== 4'b1000 || bif.sel !== 2'd3) begin
      fails++; $display("FAIL wrap_first: got grant=%b sel=%0d want 1000/3", bif.grant, bif.sel);
    end
    bif.req = 4'b0101; bif.bus_ready = 1'b1;
    tick();
    checks++;
    if (bif.grant !== 4'b0001 || bif.sel !== 2'd0) begin
      fails++; $display("FAIL wrap_to0: got grant=%b sel=%0d want 0001/0", bif.grant, bif.sel);
    end
    tick();
    checks++;
    if (bif.grant !== 4'b0100 || bif.sel !== 2'd2) begin
      fails++; $display("FAIL skip_to2: got grant=%b sel=%0d want 0100/2", bif.grant, bif.sel);
    end
    bif.req = 4'b0000;
    tick();
    bif.bus_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    bif.req = 4'b0010; bif.bus_ready = 1'b0;
    tick();
    checks++;
    if (bif.grant !== 4'b0010) begin
      fails++; $display("FAIL rmid_pre: got grant=%b want 0010", bif.grant);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if (bif.grant !== 4'b0000 || bif.bus_valid !== 1'b0 || bif.sel !== 2'd0) begin
      fails++;
      $display("FAIL rmid_abort: got grant=%b valid=%b sel=%0d want 0000/0/0",
               bif.grant, bif.bus_valid, bif.sel);
    end
    rst_n = 1'b1; bif.req = 4'b1010;
    tick();
    checks++;
    if (bif.grant !== 4'b0010 || bif.sel !== 2'd1) begin
      fails++; $display("FAIL rmid_regrant: got grant=%b sel=%0d want 0010/1", bif.grant, bif.sel);
    end
    bif.req = 4'b0000; bif.bus_ready = 1'b1;
    tick();
    bif.bus_ready = 1'b0;
  endtask

`ifdef MEM_ARB_WATCHDOG_EN
  task automatic test_watchdog();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    bif.req = 4'b0011; bif.bus_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (bif.grant !== 4'b0001 || bif.timeout_err !== 1'b0) begin
        fails++;
        $display("FAIL wd_hold cyc%0d: got grant=%b terr=%b want 0001/0", i, bif.grant, bif.timeout_err);
      end
    end
    tick();
    checks++;
    if (bif.grant !== 4'b0010 || bif.sel !== 2'd1 || bif.timeout_err !== 1'b1) begin
      fails++;
      $display("FAIL wd_fire: got grant=%b sel=%0d terr=%b want 0010/1/1",
               bif.grant, bif.sel, bif.timeout_err);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bif.grant !== 4'b0010 || bif.timeout_err !== 1'b0) begin
        fails++;
        $display("FAIL wd_pulse cyc%0d: got grant=%b terr=%b want 0010/0", i, bif.grant, bif.timeout_err);
      end
    end
    bif.bus_ready = 1'b1;
    tick();
    checks++;
    if (bif.grant !== 4'b0001 || bif.timeout_err !== 1'b0) begin
      fails++;
      $display("FAIL wd_ready_wins: got grant=%b terr=%b want 0001/0", bif.grant, bif.timeout_err);
    end
    bif.req = 4'b0000;
    tick();
    bif.bus_ready = 1'b0;
  endtask
`endif

  task automatic test_random();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    for (int i = 0; i < 500; i++) begin
      rst_n         = ($urandom_range(0, 59) != 0);
      bif.req       = 4'($urandom_range(0, 15));
      bif.bus_ready = ($urandom_range(0, 2) == 0);
      tick();
      checks++;
      if (bif.grant !== m_grant || bif.sel !== m_sel || bif.bus_valid !== m_valid) begin
        fails++;
        $display("FAIL rand cyc%0d: got grant=%b sel=%0d valid=%b want %b/%0d/%b",
                 i, bif.grant, bif.sel, bif.bus_valid, m_grant, m_sel, m_valid);
      end
`ifdef MEM_ARB_WATCHDOG_EN
      checks++;
      if (bif.timeout_err !== m_terr) begin
        fails++; $display("FAIL rand_terr cyc%0d: got %b want %b", i, bif.timeout_err, m_terr);
      end
`endif
    end
    rst_n = 1'b1; bif.req = 4'b0000; bif.bus_ready = 1'b0;
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    rst_n  = 1'b0;
    bif.req = 4'b0000;
    bif.bus_ready = 1'b0;
    test_reset();
    test_single_request();
    test_round_robin();
    test_wrap_skip();
    test_reset_mid();
`ifdef MEM_ARB_WATCHDOG_EN
    test_watchdog();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
